// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, line levels and default timing
package uart_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP = 3'd4;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam int DEF_OVERSAMPLE = 4;
  localparam int DEF_DATA_BITS = 8;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts oversample ticks and flags the last tick of each bit period
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic bit_end
);
  localparam int W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  logic [W-1:0] tick_cnt;
  assign bit_end = tick & ~clr & (tick_cnt == W'(OVERSAMPLE - 1));
  // tick counter, held at zero while cleared and wrapped at the bit boundary
  always_ff @(posedge clk)
    if (rst || clr) tick_cnt <= '0;
    else if (tick) tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: serializes a handshaked data word onto TxD as start/data/parity/stop
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 BaudTick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TxD,
  output logic                 busy,
  output logic                 done
);
  logic [2:0] state;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0] bit_cnt;
  logic par, bit_end, last_data, last_stop;
  assign tx_ready = state == ST_IDLE;
  assign busy = ~tx_ready;
  assign last_data = bit_cnt == 4'(DATA_BITS - 1);
  assign last_stop = bit_cnt == 4'(STOP_BITS - 1);
  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(tx_ready),
    .tick(BaudTick),
    .bit_end(bit_end)
  );
  // frame FSM; TxD is registered with the level of the state being entered
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      TxD <= LINE_IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      par <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE:
          if (tx_valid) begin
            shreg <= tx_data;
            par <= ^tx_data ^ (PARITY_ODD != 0);
            bit_cnt <= '0;
            state <= ST_START;
            TxD <= START_LVL;
          end
        ST_START:
          if (bit_end) begin
            state <= ST_DATA;
            TxD <= shreg[0];
          end
        ST_DATA:
          if (bit_end) begin
            shreg <= shreg >> 1;
            bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
            state <= !last_data ? ST_DATA : (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            TxD <= !last_data ? shreg[1] : (PARITY_EN != 0) ? par : LINE_IDLE;
          end
        ST_PARITY:
          if (bit_end) begin
            state <= ST_STOP;
            TxD <= LINE_IDLE;
          end
        ST_STOP:
          if (bit_end) begin
            bit_cnt <= last_stop ? '0 : bit_cnt + 1'b1;
            state <= last_stop ? ST_IDLE : ST_STOP;
            done <= last_stop;
          end
        default: begin
          state <= ST_IDLE;
          TxD <= LINE_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed checks of framing, parity, back-to-back, busy-ignore and reset
module tb_uart_tx_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic [3:0] txv = 4'b0;
  logic [7:0] td [4];
  logic [3:0] txd, rdy, bsy, dn;
  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  logic [15:0] b;

  always #5 clk = ~clk;

  uart_tx_serializer dut0 (.clk(clk), .rst(rst), .BaudTick(tick), .tx_data(td[0]), .tx_valid(txv[0]),
    .tx_ready(rdy[0]), .TxD(txd[0]), .busy(bsy[0]), .done(dn[0]));
  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (.clk(clk), .rst(rst), .BaudTick(tick),
    .tx_data(td[1]), .tx_valid(txv[1]), .tx_ready(rdy[1]), .TxD(txd[1]), .busy(bsy[1]), .done(dn[1]));
  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (.clk(clk), .rst(rst), .BaudTick(tick),
    .tx_data(td[2]), .tx_valid(txv[2]), .tx_ready(rdy[2]), .TxD(txd[2]), .busy(bsy[2]), .done(dn[2]));
  uart_tx_serializer #(.OVERSAMPLE(16), .STOP_BITS(2)) dut3 (.clk(clk), .rst(rst), .BaudTick(tick),
    .tx_data(td[3]), .tx_valid(txv[3]), .tx_ready(rdy[3]), .TxD(txd[3]), .busy(bsy[3]), .done(dn[3]));

  // BaudTick: every 2nd clock in mode 0, irregular gaps of 0..3 clocks in mode 1
  initial begin
    logic ph;
    int gap;
    ph = 1'b0;
    gap = 0;
    forever begin
      @(negedge clk);
      if (mode == 0) begin
        ph = ~ph;
        tick = ph;
      end else if (gap == 0) begin
        tick = 1'b1;
        gap = $urandom_range(0, 3);
      end else begin
        tick = 1'b0;
        gap--;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    int cyc = 0;
    while (!rdy[idx] && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    td[idx] = d;
    txv[idx] = 1'b1;
    @(posedge clk);
    #1;
    txv[idx] = 1'b0;
    chk("hs_txd", 32'(txd[idx]), 32'd0);
    chk("hs_ready", 32'(rdy[idx]), 32'd0);
  endtask

  // reference receiver: counts ticks after the handshake, samples mid-bit, flags off-boundary edges
  task automatic rx(input int idx, input int os, input int nb, output logic [15:0] bits);
    int cnt, cyc;
    logic prev, cur, t, glitch, early;
    bits = '0;
    cnt = 0;
    cyc = 0;
    prev = txd[idx];
    glitch = 1'b0;
    early = 1'b0;
    while (cnt < os * nb && cyc < 4000) begin
      @(posedge clk);
      t = tick;
      cyc++;
      if (t) cnt++;
      #1;
      cur = txd[idx];
      if (cur !== prev && !(t && cnt % os == 0)) glitch = 1'b1;
      if (cnt < os * nb && (dn[idx] || rdy[idx])) early = 1'b1;
      if (t && cnt % os == os / 2) bits[cnt / os] = cur;
      prev = cur;
    end
    chk("rx_ticks", 32'(cnt), 32'(os * nb));
    chk("rx_glitch", 32'(glitch), 32'd0);
    chk("rx_early_done_or_ready", 32'(early), 32'd0);
    chk("rx_done", 32'(dn[idx]), 32'd1);
    chk("rx_ready_back", 32'(rdy[idx]), 32'd1);
    chk("rx_line_idle", 32'(txd[idx]), 32'd1);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 4; i++) td[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd), 32'hF);
    chk("rst_ready", 32'(rdy), 32'hF);
    chk("rst_busy", 32'(bsy), 32'h0);
    chk("rst_done", 32'(dn), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, 8'hA5);
    chk("basic_busy", 32'(bsy[0]), 32'd1);
    rx(0, 4, 10, b);
    chk("basic_A5", 32'(b), 32'({1'b1, 8'hA5, 1'b0}));
    @(posedge clk);
    #1;
    chk("basic_done_once", 32'(dn[0]), 32'd0);
    send(1, 8'hA5);
    rx(1, 4, 11, b);
    chk("par_even_A5", 32'(b), 32'({1'b1, 1'b0, 8'hA5, 1'b0}));
    send(2, 8'hA5);
    rx(2, 4, 11, b);
    chk("par_odd_A5", 32'(b), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));
    send(1, 8'h01);
    rx(1, 4, 11, b);
    chk("par_even_01", 32'(b), 32'({1'b1, 1'b1, 8'h01, 1'b0}));
    td[0] = 8'h00;
    txv[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_first_start", 32'(txd[0]), 32'd0);
    td[0] = 8'hFF;
    rx(0, 4, 10, b);
    chk("b2b_00", 32'(b), 32'({1'b1, 8'h00, 1'b0}));
    @(posedge clk);
    #1;
    txv[0] = 1'b0;
    chk("b2b_gap_one_clk", 32'(txd[0]), 32'd0);
    rx(0, 4, 10, b);
    chk("b2b_FF", 32'(b), 32'({1'b1, 8'hFF, 1'b0}));
    @(posedge clk);
    #1;
    send(0, 8'h55);
    fork
      rx(0, 4, 10, b);
      begin
        repeat (30) @(posedge clk);
        #1;
        chk("ignore_ready_low", 32'(rdy[0]), 32'd0);
        td[0] = 8'h3C;
        txv[0] = 1'b1;
        @(posedge clk);
        #1;
        txv[0] = 1'b0;
      end
    join
    chk("ignore_55", 32'(b), 32'({1'b1, 8'h55, 1'b0}));
    repeat (20) @(posedge clk);
    #1;
    chk("ignore_no_frame", 32'({bsy[0], txd[0]}), 32'b01);
    send(0, 8'hF0);
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 18; c++) begin
      @(posedge clk);
      if (tick) cnt++;
      #1;
    end
    chk("rstmid_in_d3", 32'(txd[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid_txd", 32'(txd[0]), 32'd1);
    chk("rstmid_busy", 32'(bsy[0]), 32'd0);
    chk("rstmid_ready", 32'(rdy[0]), 32'd1);
    chk("rstmid_done", 32'(dn[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("rstmid_no_done", 32'({dn[0], txd[0]}), 32'b01);
    send(0, 8'h81);
    rx(0, 4, 10, b);
    chk("rstmid_81", 32'(b), 32'({1'b1, 8'h81, 1'b0}));
    mode = 1;
    @(posedge clk);
    #1;
    send(3, 8'hC3);
    rx(3, 16, 11, b);
    chk("os16_stop2_C3", 32'(b), 32'({2'b11, 8'hC3, 1'b0}));
    send(3, 8'h2D);
    rx(3, 16, 11, b);
    chk("os16_stop2_2D", 32'(b), 32'({2'b11, 8'h2D, 1'b0}));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
